vga_timing_gen: RTL and testbench

- Parametrised VGA timing generator; the next-generation replacement for the fixed 640x480 sync counter.
- Runs from the system clock and derives an internal pixel-rate enable.
- Generates hsync/vsync, the video-on window, pixel coordinates, and line/frame strobes for the text/frame renderers downstream.
- Timing, polarity and clock divide are all parameters, so other modes need no RTL edits.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_pix_div.sv | 24 ++
 rtl/vga_timing_gen.sv | 93 +++++++++
 tb/tb_vga_timing_gen.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: VGA mode timing constants and the sync-window helper.
package vga_pkg;
  localparam int VGA_CLK_DIV  = 4;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam logic VGA_HS_POL = 1'b0;
  localparam logic VGA_VS_POL = 1'b0;
  // 800x600@72 runs at 50 MHz, i.e. divide-by-2 from a 100 MHz system clock
  localparam int SVGA_CLK_DIV  = 2;
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 56;
  localparam int SVGA_H_SYNC   = 120;
  localparam int SVGA_H_BP     = 64;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 37;
  localparam int SVGA_V_SYNC   = 6;
  localparam int SVGA_V_BP     = 23;
  localparam logic SVGA_HS_POL = 1'b1;
  localparam logic SVGA_VS_POL = 1'b1;

  function automatic logic sync_act(input int cnt, input int act, input int fp, input int sync);
    return (cnt >= act + fp) && (cnt < act + fp + sync);
  endfunction
endpackage

// File: rtl/vga_pix_div.sv
// vga_pix_div: divides the system clock down to a one-clk-wide pixel enable.
module vga_pix_div
  import vga_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic p_tick
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_div <= '0;
    else if (en) r_div <= (r_div == LAST) ? '0 : r_div + DW'(1);
  end

  // reset gates the tick so CLK_DIV=1 stays quiet while held in reset
  assign p_tick = en && reset && (r_div == LAST);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync, coordinate and strobe generator.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = VGA_CLK_DIV,
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic HS_POL   = VGA_HS_POL,
  parameter logic VS_POL   = VGA_VS_POL,
  parameter int   CW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          p_tick,
  output logic [CW-1:0] px,
  output logic [CW-1:0] py,
  output logic          hsync,
  output logic          vsync,
  output logic          vidon,
  output logic          vblank,
  output logic          sol,
  output logic          sof
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (CLK_DIV < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $fatal(1, "vga_timing_gen: CLK_DIV, porch and sync parameters must be >= 1");
  end
  if ((longint'(1) << CW) < longint'(H_TOTAL) || (longint'(1) << CW) < longint'(V_TOTAL)) begin : g_bad_cw
    $fatal(1, "vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  logic          w_tick;
  logic          w_hwrap;
  logic [CW-1:0] w_px_nx;
  logic [CW-1:0] w_py_nx;
  logic [CW-1:0] r_px;
  logic [CW-1:0] r_py;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_vidon;
  logic          r_vblank;

  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .p_tick (w_tick)
  );

  always_comb begin
    w_hwrap = w_tick && (r_px == CW'(H_TOTAL - 1));
    w_px_nx = !w_tick ? r_px : w_hwrap ? '0 : r_px + CW'(1);
    w_py_nx = !w_hwrap ? r_py : (r_py == CW'(V_TOTAL - 1)) ? '0 : r_py + CW'(1);
  end

  // flags are decoded from the next counts so they line up with px/py on every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_px     <= '0;
      r_py     <= '0;
      r_hsync  <= !HS_POL;
      r_vsync  <= !VS_POL;
      r_vidon  <= 1'b0;
      r_vblank <= 1'b0;
    end else begin
      r_px     <= w_px_nx;
      r_py     <= w_py_nx;
      r_hsync  <= sync_act(int'(w_px_nx), H_ACTIVE, H_FP, H_SYNC) ~^ HS_POL;
      r_vsync  <= sync_act(int'(w_py_nx), V_ACTIVE, V_FP, V_SYNC) ~^ VS_POL;
      r_vidon  <= (int'(w_px_nx) < H_ACTIVE) && (int'(w_py_nx) < V_ACTIVE);
      r_vblank <= int'(w_py_nx) >= V_ACTIVE;
    end
  end

  assign p_tick = w_tick;
  assign px     = r_px;
  assign py     = r_py;
  assign hsync  = r_hsync;
  assign vsync  = r_vsync;
  assign vidon  = r_vidon;
  assign vblank = r_vblank;
  assign sol    = w_tick && (r_px == '0);
  assign sof    = sol && (r_py == '0);
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of default, reduced and short-frame VGA timing.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  logic en_a, en_b, en_c;
  logic a_tick, a_hs, a_vs, a_vo, a_vb, a_sol, a_sof;
  logic b_tick, b_hs, b_vs, b_vo, b_vb, b_sol, b_sof;
  logic c_tick, c_hs, c_vs, c_vo, c_vb, c_sol, c_sof;
  logic [9:0] a_px, a_py, c_px, c_py;
  logic [3:0] b_px, b_py;
  int n_cmp = 0;
  int n_bad = 0;
  int a_vid = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .clk(clk), .reset(rst_a), .en(en_a), .p_tick(a_tick), .px(a_px), .py(a_py),
    .hsync(a_hs), .vsync(a_vs), .vidon(a_vo), .vblank(a_vb), .sol(a_sol), .sof(a_sof)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .CW(4)
  ) u_sml (
    .clk(clk), .reset(rst_b), .en(en_b), .p_tick(b_tick), .px(b_px), .py(b_py),
    .hsync(b_hs), .vsync(b_vs), .vidon(b_vo), .vblank(b_vb), .sol(b_sol), .sof(b_sof)
  );

  // default horizontal timing with an 8-line frame so vsync/frame wrap fit the cycle budget
  vga_timing_gen #(
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_mid (
    .clk(clk), .reset(rst_c), .en(en_c), .p_tick(c_tick), .px(c_px), .py(c_py),
    .hsync(c_hs), .vsync(c_vs), .vidon(c_vo), .vblank(c_vb), .sol(c_sol), .sof(c_sof)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({a_px, a_py, a_tick, a_hs, a_vs, a_vo, a_vb, a_sol, a_sof} !== {20'd0, 7'b0110000}) begin
      n_bad++;
      $display("FAIL reset_def: got %b want %b", {a_px, a_py, a_tick, a_hs, a_vs, a_vo, a_vb, a_sol, a_sof}, {20'd0, 7'b0110000});
    end
    n_cmp++;
    if ({b_px, b_py, b_tick, b_hs, b_vs, b_vo, b_vb, b_sol, b_sof} !== {8'd0, 7'b0000000}) begin
      n_bad++;
      $display("FAIL reset_small: got %b want %b", {b_px, b_py, b_tick, b_hs, b_vs, b_vo, b_vb, b_sol, b_sof}, 15'd0);
    end
  endtask

  task automatic test_divider();
    rst_a = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_tick, a_px, a_vo, a_hs} !== {(k % 4) == 3, 10'(k / 4), 2'b11}) begin
        n_bad++;
        $display("FAIL divider k=%0d: tick/px/vidon/hs got %b/%0d/%b/%b want %b/%0d/1/1", k, a_tick, a_px, a_vo, a_hs, (k % 4) == 3, k / 4);
      end
      if (a_tick && a_vo) a_vid++;
    end
  endtask

  task automatic test_line();
    bit wrapped = 0;
    bit done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (a_py == 10'd1) done = 1;
      else begin
        n_cmp++;
        if ({a_hs, a_vs, a_vo, a_vb, a_sol, a_sof} !== {!(a_px >= 656 && a_px <= 751), 1'b1, a_px < 640, 1'b0,
                                                         a_tick && a_px == 0, a_tick && a_px == 0}) begin
          n_bad++;
          $display("FAIL line0 px=%0d: hs/vs/vo/vb/sol/sof got %b%b%b%b%b%b", a_px, a_hs, a_vs, a_vo, a_vb, a_sol, a_sof);
        end
        if (a_tick && a_vo) a_vid++;
        if (a_tick && a_px == 10'd799) wrapped = 1;
      end
    end
    n_cmp++;
    if ({done, wrapped, a_px} !== {2'b11, 10'd0}) begin
      n_bad++;
      $display("FAIL hwrap: done/wrapped/px got %b/%b/%0d want 1/1/0", done, wrapped, a_px);
    end
    n_cmp++;
    if (a_vid !== 640) begin
      n_bad++;
      $display("FAIL vidon_ticks: got %0d want 640", a_vid);
    end
  endtask

  task automatic test_en_freeze();
    bit found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (a_px == 10'd299 && a_tick) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL freeze_seek: px=299 tick not reached, px=%0d", a_px);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({a_px, a_py, a_tick} !== {10'd300, 10'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL freeze_start: px/py/tick got %0d/%0d/%b want 300/1/0", a_px, a_py, a_tick);
    end
    en_a = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_px, a_py, a_tick, a_sol, a_sof, a_hs, a_vs, a_vo, a_vb} !== {10'd300, 10'd1, 7'b0001110}) begin
        n_bad++;
        $display("FAIL frozen i=%0d: px/py=%0d/%0d flags %b%b%b%b%b%b%b", i, a_px, a_py, a_tick, a_sol, a_sof, a_hs, a_vs, a_vo, a_vb);
      end
    end
    en_a = 1'b1;
    #1;
    n_cmp++;
    if (a_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL resume_now: tick got %b want 0", a_tick);
    end
    @(negedge clk);
    n_cmp++;
    if ({a_px, a_tick} !== {10'd300, 1'b1}) begin
      n_bad++;
      $display("FAIL resume_tick: px/tick got %0d/%b want 300/1", a_px, a_tick);
    end
    @(negedge clk);
    n_cmp++;
    if ({a_px, a_tick} !== {10'd301, 1'b0}) begin
      n_bad++;
      $display("FAIL resume_px: px/tick got %0d/%b want 301/0", a_px, a_tick);
    end
  endtask

  task automatic test_small_frame();
    logic [3:0] ex_px = 4'd1;
    logic [3:0] ex_py = 4'd0;
    logic [14:0] exp_v;
    int vid = 0;
    int sof_n = 0;
    int sof_at[2] = '{-1, -1};
    rst_b = 1'b1;
    for (int i = 0; i < 168; i++) begin
      @(negedge clk);
      exp_v = {ex_px, ex_py, 1'b1, ex_px >= 9 && ex_px <= 10, ex_py == 5, ex_px < 8 && ex_py < 4, ex_py >= 4,
               ex_px == 0, ex_px == 0 && ex_py == 0};
      n_cmp++;
      if ({b_px, b_py, b_tick, b_hs, b_vs, b_vo, b_vb, b_sol, b_sof} !== exp_v) begin
        n_bad++;
        $display("FAIL small i=%0d: got %b want %b", i, {b_px, b_py, b_tick, b_hs, b_vs, b_vo, b_vb, b_sol, b_sof}, exp_v);
      end
      if (b_vo) vid++;
      if (b_sof) begin
        if (sof_n < 2) sof_at[sof_n] = i;
        sof_n++;
      end
      if (ex_px == 4'd11) begin
        ex_px = 4'd0;
        ex_py = (ex_py == 4'd6) ? 4'd0 : ex_py + 4'd1;
      end else ex_px = ex_px + 4'd1;
    end
    n_cmp++;
    if (sof_n !== 2 || sof_at[1] - sof_at[0] !== 84) begin
      n_bad++;
      $display("FAIL small_frame: sof count %0d period %0d want 2 and 84", sof_n, sof_at[1] - sof_at[0]);
    end
    n_cmp++;
    if (vid !== 64) begin
      n_bad++;
      $display("FAIL small_vidon: got %0d want 64", vid);
    end
  endtask

  task automatic test_mid_frame();
    int sof_n = 0;
    int sof_at[2] = '{-1, -1};
    int max_py = 0;
    rst_c = 1'b1;
    for (int i = 0; i < 27000 && sof_n < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({c_hs, c_vs, c_vo, c_vb, c_sof} !== {!(c_px >= 656 && c_px <= 751), !(c_py >= 5 && c_py <= 6),
                                               c_px < 640 && c_py < 4, c_py >= 4, c_tick && c_px == 0 && c_py == 0}) begin
        n_bad++;
        $display("FAIL skew px=%0d py=%0d: hs/vs/vo/vb/sof got %b%b%b%b%b", c_px, c_py, c_hs, c_vs, c_vo, c_vb, c_sof);
      end
      if (int'(c_py) > max_py) max_py = int'(c_py);
      if (c_sof) begin
        sof_at[sof_n] = i;
        sof_n++;
      end
    end
    n_cmp++;
    if (sof_n !== 2 || sof_at[1] - sof_at[0] !== 25600 || max_py !== 7) begin
      n_bad++;
      $display("FAIL mid_frame: sofs %0d period %0d max_py %0d want 2/25600/7", sof_n, sof_at[1] - sof_at[0], max_py);
    end
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    for (int i = 0; i < 25000 && !found; i++) begin
      @(negedge clk);
      if (c_px == 10'd700 && c_py == 10'd5) found = 1;
    end
    n_cmp++;
    if ({found, c_hs, c_vs, c_vb} !== 4'b1001) begin
      n_bad++;
      $display("FAIL pre_reset: found/hs/vs/vb got %b%b%b%b want 1001", found, c_hs, c_vs, c_vb);
    end
    rst_c = 1'b0;
    #1;
    n_cmp++;
    if ({c_px, c_py, c_tick, c_hs, c_vs, c_vo, c_vb, c_sol, c_sof} !== {20'd0, 7'b0110000}) begin
      n_bad++;
      $display("FAIL async_reset: got %b", {c_px, c_py, c_tick, c_hs, c_vs, c_vo, c_vb, c_sol, c_sof});
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({c_px, c_py, c_tick, c_hs, c_vs, c_vo, c_vb, c_sol, c_sof} !== {20'd0, 7'b0110000}) begin
      n_bad++;
      $display("FAIL held_reset: got %b", {c_px, c_py, c_tick, c_hs, c_vs, c_vo, c_vb, c_sol, c_sof});
    end
    rst_c = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({c_px, c_tick, c_vo, c_hs, c_vs} !== {10'd0, 4'b0111}) begin
      n_bad++;
      $display("FAIL release_edge1: px/tick/vo/hs/vs got %0d/%b%b%b%b want 0/0111", c_px, c_tick, c_vo, c_hs, c_vs);
    end
    @(negedge clk);
    n_cmp++;
    if (c_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL release_edge2: tick got %b want 0", c_tick);
    end
    @(negedge clk);
    n_cmp++;
    if ({c_tick, c_sof} !== 2'b11) begin
      n_bad++;
      $display("FAIL release_tick: tick/sof got %b%b want 11", c_tick, c_sof);
    end
    @(negedge clk);
    n_cmp++;
    if ({c_px, c_tick} !== {10'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL release_px: px/tick got %0d/%b want 1/0", c_px, c_tick);
    end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    en_a = 1'b1;
    en_b = 1'b1;
    en_c = 1'b1;
    test_reset();
    test_divider();
    test_line();
    test_en_freeze();
    test_small_frame();
    test_mid_frame();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
